// File: rtl/lc3b_types.sv
// Shared LC-3b types for the memory-stage access sequencer.
package lc3b_types;

  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_SECOND, S_DONE} lc3b_memseq_state;

  typedef enum logic [2:0] {NONE, READ, WRITE, LDI, STI, TRAP} lc3b_mem_kind;

  typedef logic [1:0] lc3b_mem_be;

  localparam lc3b_mem_be BE_WORD = 2'b11;

  // Indirect kinds win over plain read/write since their control words also set those bits.
  function automatic lc3b_mem_kind decode_kind(input logic mem_read, input logic mem_write,
                                               input logic ldi_ind, input logic sti_ind,
                                               input logic trap_ind);
    if (sti_ind) return STI;
    if (ldi_ind) return LDI;
    if (trap_ind) return TRAP;
    if (mem_write) return WRITE;
    if (mem_read) return READ;
    return NONE;
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Byte-lane steering for LDB/STB: store replication, byte enables, load select + sign-extend.
module byte_lane_align
  import lc3b_types::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  addr_lsb,
  input  logic                  stb,
  input  logic                  ldb,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [DATA_WIDTH-1:0] rdata,
  output lc3b_mem_be            byte_enable,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_value
);

  logic [7:0] sel_byte;

  always_comb begin
    byte_enable = BE_WORD;
    wdata       = store_data;
    if (stb) begin
      byte_enable = addr_lsb ? 2'b10 : 2'b01;
      wdata       = {store_data[7:0], store_data[7:0]};
    end
  end

  always_comb begin
    sel_byte   = addr_lsb ? rdata[15:8] : rdata[7:0];
    load_value = rdata;
    if (ldb) load_value = {{(DATA_WIDTH - 8){sel_byte[7]}}, sel_byte};
  end

endmodule

// File: rtl/mem_access_seq.sv
// MEM-stage access sequencer: turns LC-3b control bits into one or two data-memory transactions.
// Optional MEMSEQ_PERF_EN adds stall_cycles / indirect_count performance counters.
module mem_access_seq
  import lc3b_types::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  ldi_ind,
  input  logic                  sti_ind,
  input  logic                  trap_ind,
  input  logic                  ldb_ind,
  input  logic                  stb_ind,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  input  logic                  dmem_resp,
  output logic                  dmem_read,
  output logic                  dmem_write,
  output logic [DATA_WIDTH-1:0] dmem_address,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output lc3b_mem_be            dmem_byte_enable,
  output logic [DATA_WIDTH-1:0] load_data,
`ifdef MEMSEQ_PERF_EN
  output logic [31:0]           stall_cycles,
  output logic [15:0]           indirect_count,
`endif
  output logic                  mem_stall
);

  lc3b_memseq_state      state_q, state_d;
  lc3b_mem_kind          kind_in, kind_q;
  logic [DATA_WIDTH-1:0] addr_q, store_q, ptr_q, load_data_q;
  logic                  ldb_q, stb_q, start;
  lc3b_mem_be            align_be;
  logic [DATA_WIDTH-1:0] align_wdata, align_load;

  assign kind_in   = decode_kind(mem_read, mem_write, ldi_ind, sti_ind, trap_ind);
  assign start     = valid && (kind_in != NONE);
  assign load_data = load_data_q;

  byte_lane_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .addr_lsb   (addr_q[0]),
    .stb        (stb_q),
    .ldb        (ldb_q),
    .store_data (store_q),
    .rdata      (dmem_rdata),
    .byte_enable(align_be),
    .wdata      (align_wdata),
    .load_value (align_load)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_FIRST;
      S_FIRST:  if (dmem_resp) state_d = (kind_q == LDI || kind_q == STI) ? S_SECOND : S_DONE;
      S_SECOND: if (dmem_resp) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_address     = '0;
    dmem_wdata       = '0;
    dmem_byte_enable = BE_WORD;
    mem_stall        = 1'b0;
    unique case (state_q)
      S_IDLE:  mem_stall = start;
      S_FIRST: begin
        mem_stall    = 1'b1;
        dmem_address = addr_q;
        if (kind_q == WRITE) begin
          dmem_write       = 1'b1;
          dmem_wdata       = align_wdata;
          dmem_byte_enable = align_be;
        end else begin
          dmem_read = 1'b1;
        end
      end
      S_SECOND: begin
        mem_stall    = 1'b1;
        dmem_address = ptr_q;
        if (kind_q == STI) begin
          dmem_write = 1'b1;
          dmem_wdata = store_q;
        end else begin
          dmem_read = 1'b1;
        end
      end
      S_DONE: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      store_q     <= '0;
      ptr_q       <= '0;
      kind_q      <= NONE;
      ldb_q       <= 1'b0;
      stb_q       <= 1'b0;
      load_data_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) begin
          addr_q  <= addr;
          store_q <= store_data;
          kind_q  <= kind_in;
          ldb_q   <= ldb_ind;
          stb_q   <= stb_ind;
        end
        S_FIRST: if (dmem_resp) begin
          if (kind_q == LDI || kind_q == STI) ptr_q <= dmem_rdata;
          else if (kind_q != WRITE)           load_data_q <= align_load;
        end
        // The pointed-to word is always a full-word access.
        S_SECOND: if (dmem_resp && kind_q == LDI) load_data_q <= dmem_rdata;
        S_DONE: ;
      endcase
    end
  end

`ifdef MEMSEQ_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] indirect_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q   <= '0;
      indirect_count_q <= '0;
    end else begin
      if (mem_stall && stall_cycles_q != 32'hFFFF_FFFF) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (state_q != S_SECOND && state_d == S_SECOND) indirect_count_q <= indirect_count_q + 16'd1;
    end
  end

  assign stall_cycles   = stall_cycles_q;
  assign indirect_count = indirect_count_q;
`endif

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed self-checking bench for mem_access_seq with a small responding data memory.
module tb_mem_access_seq;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        reset, valid;
  logic        mem_read, mem_write, ldi_ind, sti_ind, trap_ind, ldb_ind, stb_ind;
  logic [15:0] addr, store_data, dmem_rdata;
  logic        dmem_resp;
  logic        dmem_read, dmem_write, mem_stall;
  logic [15:0] dmem_address, dmem_wdata, load_data;
  logic [1:0]  dmem_byte_enable;
`ifdef MEMSEQ_PERF_EN
  logic [31:0] stall_cycles;
  logic [15:0] indirect_count;
`endif

  int chk_cnt = 0;
  int pass_cnt = 0;

  // Per-access observations gathered by do_access
  int          n_txn, stall_n;
  logic        done_req, timeout;
  logic [15:0] t_addr[2];
  logic [15:0] t_wdata[2];
  logic        t_we[2];
  logic [1:0]  t_be[2];

  // {mem_read, mem_write, ldi, sti, trap, ldb, stb}
  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_READ  = 7'b1000000;
  localparam logic [6:0] C_WRITE = 7'b0100000;
  localparam logic [6:0] C_LDI   = 7'b0010000;
  localparam logic [6:0] C_STI   = 7'b0001000;
  localparam logic [6:0] C_TRAP  = 7'b0000100;
  localparam logic [6:0] C_LDB   = 7'b1000010;
  localparam logic [6:0] C_STB   = 7'b0100001;

  always #5 clk = ~clk;

  mem_access_seq dut (
    .clk             (clk),
    .reset           (reset),
    .valid           (valid),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .ldi_ind         (ldi_ind),
    .sti_ind         (sti_ind),
    .trap_ind        (trap_ind),
    .ldb_ind         (ldb_ind),
    .stb_ind         (stb_ind),
    .addr            (addr),
    .store_data      (store_data),
    .dmem_rdata      (dmem_rdata),
    .dmem_resp       (dmem_resp),
    .dmem_read       (dmem_read),
    .dmem_write      (dmem_write),
    .dmem_address    (dmem_address),
    .dmem_wdata      (dmem_wdata),
    .dmem_byte_enable(dmem_byte_enable),
    .load_data       (load_data),
`ifdef MEMSEQ_PERF_EN
    .stall_cycles    (stall_cycles),
    .indirect_count  (indirect_count),
`endif
    .mem_stall       (mem_stall)
  );

  task automatic set_ctl(input logic [6:0] ctl);
    {mem_read, mem_write, ldi_ind, sti_ind, trap_ind, ldb_ind, stb_ind} = ctl;
  endtask

  // Drives one instruction and answers each request after `delay` waiting cycles.
  task automatic do_access(input logic [6:0] ctl, input logic [15:0] a, input logic [15:0] sd,
                           input logic [15:0] r0, input logic [15:0] r1, input int delay);
    int   wt;
    logic began;
    wt = 0; began = 1'b0;
    n_txn = 0; stall_n = 0; done_req = 1'b0; timeout = 1'b1;
    set_ctl(ctl); addr = a; store_data = sd; valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_stall) begin
        stall_n++;
        began = 1'b1;
      end else if (began) begin
        done_req = dmem_read | dmem_write;
        timeout  = 1'b0;
      end
      if ((dmem_read || dmem_write) && n_txn < 2) begin
        if (wt == delay) begin
          t_addr[n_txn]  = dmem_address;
          t_we[n_txn]    = dmem_write;
          t_wdata[n_txn] = dmem_wdata;
          t_be[n_txn]    = dmem_byte_enable;
          dmem_rdata     = (n_txn == 0) ? r0 : r1;
          dmem_resp      = 1'b1;
          n_txn++;
          wt = 0;
        end else begin
          wt++;
        end
      end
      @(posedge clk); #1;
      dmem_resp = 1'b0;
      if (!timeout) break;
    end
    valid = 1'b0;
    set_ctl(C_NONE);
  endtask

  task automatic test_reset;
    reset = 1'b1; valid = 1'b0; set_ctl(C_NONE);
    addr = '0; store_data = '0; dmem_rdata = '0; dmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if ({dmem_read, dmem_write, mem_stall} !== 3'b000 || dmem_address !== 16'h0 ||
        dmem_wdata !== 16'h0 || dmem_byte_enable !== 2'b11)
      $display("FAIL reset_outputs: rd=%b wr=%b stall=%b addr=%h wdata=%h be=%b, need 0 0 0 0 0 11",
               dmem_read, dmem_write, mem_stall, dmem_address, dmem_wdata, dmem_byte_enable);
    else pass_cnt++;
    chk_cnt++;
    if (load_data !== 16'h0) $display("FAIL reset_load_data: got %h need 0000", load_data);
    else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_ldr;
    do_access(C_READ, 16'h3000, 16'h0, 16'h1234, 16'h0, 2);
    chk_cnt++;
    if (timeout || n_txn != 1 || t_we[0] !== 1'b0 || t_addr[0] !== 16'h3000)
      $display("FAIL ldr_txn: to=%b n=%0d we=%b addr=%h need 0 1 0 3000",
               timeout, n_txn, t_we[0], t_addr[0]);
    else pass_cnt++;
    chk_cnt++;
    if (load_data !== 16'h1234) $display("FAIL ldr_load: got %h need 1234", load_data);
    else pass_cnt++;
    chk_cnt++;
    if (stall_n != 4 || done_req !== 1'b0)
      $display("FAIL ldr_stall: stall=%0d done_req=%b need 4 0", stall_n, done_req);
    else pass_cnt++;
  endtask

  task automatic test_ldi;
    do_access(C_LDI, 16'h4000, 16'h0, 16'h5002, 16'hBEEF, 1);
    chk_cnt++;
    if (timeout || n_txn != 2 || t_we[0] !== 1'b0 || t_we[1] !== 1'b0 ||
        t_addr[0] !== 16'h4000 || t_addr[1] !== 16'h5002)
      $display("FAIL ldi_txn: to=%b n=%0d we=%b%b addr=%h,%h need 0 2 00 4000,5002",
               timeout, n_txn, t_we[0], t_we[1], t_addr[0], t_addr[1]);
    else pass_cnt++;
    chk_cnt++;
    if (load_data !== 16'hBEEF || stall_n != 5)
      $display("FAIL ldi_load: load=%h stall=%0d need beef 5", load_data, stall_n);
    else pass_cnt++;
  endtask

  task automatic test_sti;
    do_access(C_STI, 16'h4000, 16'hCAFE, 16'h6000, 16'h0, 0);
    chk_cnt++;
    if (timeout || n_txn != 2 || t_we[0] !== 1'b0 || t_addr[0] !== 16'h4000)
      $display("FAIL sti_ptr_read: to=%b n=%0d we=%b addr=%h need 0 2 0 4000",
               timeout, n_txn, t_we[0], t_addr[0]);
    else pass_cnt++;
    chk_cnt++;
    if (t_we[1] !== 1'b1 || t_addr[1] !== 16'h6000 || t_wdata[1] !== 16'hCAFE || t_be[1] !== 2'b11)
      $display("FAIL sti_write: we=%b addr=%h wdata=%h be=%b need 1 6000 cafe 11",
               t_we[1], t_addr[1], t_wdata[1], t_be[1]);
    else pass_cnt++;
    chk_cnt++;
    if (load_data !== 16'hBEEF) $display("FAIL sti_load_kept: got %h need beef", load_data);
    else pass_cnt++;
  endtask

  task automatic test_stores;
    do_access(C_STB, 16'h2001, 16'h00A5, 16'h0, 16'h0, 0);
    chk_cnt++;
    if (timeout || n_txn != 1 || t_we[0] !== 1'b1 || t_be[0] !== 2'b10 || t_wdata[0] !== 16'hA5A5 ||
        t_addr[0] !== 16'h2001 || stall_n != 2)
      $display("FAIL stb_hi: n=%0d we=%b be=%b wdata=%h addr=%h stall=%0d need 1 1 10 a5a5 2001 2",
               n_txn, t_we[0], t_be[0], t_wdata[0], t_addr[0], stall_n);
    else pass_cnt++;
    do_access(C_STB, 16'h2000, 16'h1234, 16'h0, 16'h0, 1);
    chk_cnt++;
    if (timeout || t_we[0] !== 1'b1 || t_be[0] !== 2'b01 || t_wdata[0] !== 16'h3434)
      $display("FAIL stb_lo: we=%b be=%b wdata=%h need 1 01 3434", t_we[0], t_be[0], t_wdata[0]);
    else pass_cnt++;
    do_access(C_WRITE, 16'h3002, 16'hCAFE, 16'h0, 16'h0, 0);
    chk_cnt++;
    if (timeout || t_we[0] !== 1'b1 || t_be[0] !== 2'b11 || t_wdata[0] !== 16'hCAFE ||
        t_addr[0] !== 16'h3002)
      $display("FAIL str_word: we=%b be=%b wdata=%h addr=%h need 1 11 cafe 3002",
               t_we[0], t_be[0], t_wdata[0], t_addr[0]);
    else pass_cnt++;
  endtask

  task automatic test_ldb;
    do_access(C_LDB, 16'h2001, 16'h0, 16'h80FF, 16'h0, 0);
    chk_cnt++;
    if (timeout || load_data !== 16'hFF80 || t_we[0] !== 1'b0)
      $display("FAIL ldb_hi: load=%h we=%b need ff80 0", load_data, t_we[0]);
    else pass_cnt++;
    do_access(C_LDB, 16'h2000, 16'h0, 16'h1234, 16'h0, 0);
    chk_cnt++;
    if (timeout || load_data !== 16'h0034) $display("FAIL ldb_lo: load=%h need 0034", load_data);
    else pass_cnt++;
    do_access(C_LDB, 16'h2000, 16'h0, 16'h80FF, 16'h0, 0);
    chk_cnt++;
    if (timeout || load_data !== 16'hFFFF) $display("FAIL ldb_lo_neg: load=%h need ffff", load_data);
    else pass_cnt++;
  endtask

  task automatic test_add_passthrough;
    valid = 1'b1; set_ctl(C_NONE); addr = 16'h1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      // A stray response while idle must be ignored
      dmem_resp = (c == 1); dmem_rdata = 16'hFFFF;
      chk_cnt++;
      if (mem_stall !== 1'b0 || dmem_read !== 1'b0 || dmem_write !== 1'b0)
        $display("FAIL add_no_stall: stall=%b rd=%b wr=%b need 0 0 0", mem_stall, dmem_read, dmem_write);
      else pass_cnt++;
      @(posedge clk); #1;
      dmem_resp = 1'b0;
    end
    valid = 1'b0;
    chk_cnt++;
    if (load_data !== 16'hFFFF) $display("FAIL add_load_kept: got %h need ffff", load_data);
    else pass_cnt++;
  endtask

  task automatic test_trap;
    do_access(C_TRAP, 16'h004A, 16'h0, 16'h0400, 16'h0, 1);
    chk_cnt++;
    if (timeout || n_txn != 1 || t_we[0] !== 1'b0 || t_addr[0] !== 16'h004A ||
        load_data !== 16'h0400 || stall_n != 3)
      $display("FAIL trap_vector: n=%0d we=%b addr=%h load=%h stall=%0d need 1 0 004a 0400 3",
               n_txn, t_we[0], t_addr[0], load_data, stall_n);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    do_access(C_READ, 16'h3100, 16'h0, 16'h1111, 16'h0, 0);
    chk_cnt++;
    if (timeout || load_data !== 16'h1111 || done_req !== 1'b0 || stall_n != 2)
      $display("FAIL b2b_first: load=%h done_req=%b stall=%0d need 1111 0 2",
               load_data, done_req, stall_n);
    else pass_cnt++;
    do_access(C_READ, 16'h3102, 16'h0, 16'h2222, 16'h0, 0);
    chk_cnt++;
    if (timeout || load_data !== 16'h2222 || t_addr[0] !== 16'h3102 || n_txn != 1)
      $display("FAIL b2b_second: load=%h addr=%h n=%0d need 2222 3102 1",
               load_data, t_addr[0], n_txn);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_ldi;
    logic seen;
    seen = 1'b0;
    valid = 1'b1; set_ctl(C_LDI); addr = 16'h4000;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dmem_read && dmem_address == 16'h5002) begin
        seen  = 1'b1;
        reset = 1'b1;
      end else if (dmem_read) begin
        dmem_resp = 1'b1; dmem_rdata = 16'h5002;
      end
      @(posedge clk); #1;
      dmem_resp = 1'b0;
      if (seen) break;
    end
    reset = 1'b0; valid = 1'b0; set_ctl(C_NONE);
    dmem_resp = 1'b1; dmem_rdata = 16'hDEAD;
    chk_cnt++;
    if (!seen) $display("FAIL rst_mid_reach_second: second read not seen, need it");
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (dmem_read !== 1'b0 || mem_stall !== 1'b0 || load_data !== 16'h0 || dut.state_q !== S_IDLE)
      $display("FAIL rst_mid_drop: rd=%b stall=%b load=%h state=%0d need 0 0 0000 0",
               dmem_read, mem_stall, load_data, dut.state_q);
    else pass_cnt++;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (dmem_read !== 1'b0 || load_data !== 16'h0 || dut.state_q !== S_IDLE)
      $display("FAIL rst_mid_late_resp: rd=%b load=%h state=%0d need 0 0000 0",
               dmem_read, load_data, dut.state_q);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_ldr();
    test_ldi();
    test_sti();
    test_stores();
    test_ldb();
    test_add_passthrough();
    test_trap();
    test_back_to_back();
    test_reset_mid_ldi();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Memory-stage access sequencer for the pipelined LC-3b core.
- Takes the MEM-stage control bits (mem_read, mem_write, ldi_ind, sti_ind, trap_ind, ldb_ind, stb_ind) and turns them into one or two data-memory transactions.
- Stalls the pipeline until those transactions complete.
- Handles indirect access for LDI/STI, byte-lane alignment for LDB/STB, and the TRAP vector fetch.

Parameters:
- DATA_WIDTH, 16, word and address width (lc3b_word).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- valid  in  1  MEM stage holds a real instruction
- mem_read  in  1  control word: read access
- mem_write  in  1  control word: write access
- ldi_ind  in  1  control word: LDI indirect read
- sti_ind  in  1  control word: STI indirect write
- trap_ind  in  1  control word: TRAP vector read
- ldb_ind  in  1  control word: byte load
- stb_ind  in  1  control word: byte store
- addr  in  16  effective address from the address adder
- store_data  in  16  SR value for stores
- dmem_rdata  in  16  data memory read data
- dmem_resp  in  1  data memory response (one-cycle pulse)
- dmem_read  out  1  data memory read request
- dmem_write  out  1  data memory write request
- dmem_address  out  16  data memory address
- dmem_wdata  out  16  data memory write data
- dmem_byte_enable  out  2  byte lanes, [1] = high byte
- load_data  out  16  result to the WB data mux
- mem_stall  out  1  hold IF..MEM pipeline registers

Behaviour:
- Clocking: single clock, clk. reset is synchronous and active-high.
- States (lc3b_memseq_state): S_IDLE, S_FIRST, S_SECOND, S_DONE.
- Reset: state = S_IDLE, load_data = 0, all captured registers = 0.
  - Outputs during and after reset: dmem_read = 0, dmem_write = 0, dmem_address = 0, dmem_wdata = 0, dmem_byte_enable = 2'b11, mem_stall = 0.
- Access kind decode, in priority order: sti_ind → STI, ldi_ind → LDI, trap_ind → TRAP, mem_write → WRITE, mem_read → READ, else NONE.
- S_IDLE:
  - If valid and kind != NONE: capture addr, store_data, kind, ldb_ind and stb_ind. Assert mem_stall combinationally in this cycle. Go to S_FIRST.
  - Otherwise mem_stall = 0.
- S_FIRST:
  - mem_stall = 1. dmem_address = captured addr.
  - WRITE: dmem_write = 1. Otherwise dmem_read = 1.
  - Requests are held stable until dmem_resp.
  - On dmem_resp:
    - LDI or STI: capture dmem_rdata as the pointer, go to S_SECOND.
    - Otherwise: update load_data (reads only), go to S_DONE.
- S_SECOND:
  - mem_stall = 1. dmem_address = pointer, full word.
  - LDI: dmem_read = 1. STI: dmem_write = 1 with dmem_wdata = store_data.
  - On dmem_resp: LDI updates load_data. Go to S_DONE.
- S_DONE:
  - mem_stall = 0 for exactly one cycle so the pipeline advances; no requests issued. Next state S_IDLE.
  - An instruction is never re-issued: the next S_IDLE cycle sees the new MEM-stage occupant.
- Byte alignment (captured addr[0]):
  - STB: dmem_byte_enable = addr[0] ? 2'b10 : 2'b01; dmem_wdata = {store_data[7:0], store_data[7:0]}.
  - LDB: load_data = sign-extend of (addr[0] ? rdata[15:8] : rdata[7:0]).
  - Word accesses: dmem_byte_enable = 2'b11. The address is passed unmodified; the memory ignores bit 0.
- Latency:
  - Single access: 1 cycle (IDLE) + N cycles waiting for response + 1 cycle (DONE).
  - Indirect access: two memory waits.
- dmem_resp outside S_FIRST/S_SECOND is ignored.
- Reset mid-transaction: the request is dropped the next cycle. A late dmem_resp is ignored.
- valid low, or kind NONE: no state change and mem_stall = 0. All non-memory opcodes pass through with zero added cycles.

Optional Feature:
- Macro: MEMSEQ_PERF_EN.
- Defined:
  - Adds output port stall_cycles (32 bits), reset to 0.
  - Increments every cycle mem_stall = 1, saturating at 32'hFFFF_FFFF.
  - Adds output indirect_count (16 bits), which increments on each entry to S_SECOND and wraps.
- Undefined: neither port nor counter exists; function is otherwise identical.

Decomposition:
- Shared package lc3b_types gets:
  - lc3b_memseq_state enum
  - lc3b_mem_kind enum {NONE, READ, WRITE, LDI, STI, TRAP}
  - lc3b_mem_be 2-bit typedef
- Sub-module byte_lane_align (combinational) covers:
  - STB lane replication and byte enable
  - LDB byte select and sign-extend
- The FSM and capture registers stay in mem_access_seq.

Test Plan:
- LDR: addr 0x3000, resp after 2 cycles with rdata 0x1234 → one read at 0x3000, load_data = 0x1234, mem_stall high 4 cycles, then low 1 cycle.
- LDI: addr 0x4000 → rdata 0x5002 → rdata 0xBEEF → reads at 0x4000 then 0x5002, load_data = 0xBEEF, no write issued.
- STI: addr 0x4000 → rdata 0x6000, store_data 0xCAFE → read at 0x4000, then write at 0x6000 with wdata 0xCAFE and be 2'b11.
- STB / LDB:
  - STB at 0x2001 with store_data 0x00A5 → be 2'b10, wdata 0xA5A5.
  - LDB at 0x2001 with rdata 0x80FF → load_data 0xFF80.
- Reset mid-LDI: assert reset in S_SECOND, then give dmem_resp → dmem_read = 0 next cycle, state S_IDLE, load_data = 0.
- ADD with valid high, then TRAP x25 at addr 0x004A → ADD: mem_stall never asserts. TRAP: single read at 0x004A, load_data = returned vector.
